// File: rtl/li_encoder_pkg.sv
// Shared load-immediate ISA encoding: K field, k1 opcodes, field positions and word helpers.
// Used by li_encoder, li_next_chunk and the instruction decoder.
package li_encoder_pkg;

  localparam int INSN_W      = 32;
  localparam int VALUE_W     = 64;
  localparam int DST_W       = 5;
  localparam int CHUNK_W     = 16;
  localparam int NUM_CHUNKS  = VALUE_W / CHUNK_W;
  localparam int CHUNK_IDX_W = 2;

  localparam int K_MSB   = 30;
  localparam int K_LSB   = 29;
  localparam int DST_MSB = 24;
  localparam int DST_LSB = 20;
  localparam int K1_MSB  = 19;
  localparam int K1_LSB  = 16;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  localparam logic [K_MSB-K_LSB:0]   K_LOADIMM = 2'b01;
  localparam logic [K1_MSB-K1_LSB:0] K1_LI     = 4'd0;
  localparam logic [K1_MSB-K1_LSB:0] K1_LIU    = 4'd1;
  localparam logic [K1_MSB-K1_LSB:0] K1_LIUU   = 4'd2;
  localparam logic [K1_MSB-K1_LSB:0] K1_LIUUU  = 4'd3;

  typedef enum logic {
    ST_IDLE,
    ST_EMIT
  } state_e;

  function automatic logic [K1_MSB-K1_LSB:0] k1_of(input logic [CHUNK_IDX_W-1:0] n);
    logic [K1_MSB-K1_LSB:0] k1;
    case (n)
      2'd0:    k1 = K1_LI;
      2'd1:    k1 = K1_LIU;
      2'd2:    k1 = K1_LIUU;
      default: k1 = K1_LIUUU;
    endcase
    return k1;
  endfunction

  function automatic logic [CHUNK_W-1:0] li_chunk(input logic [VALUE_W-1:0] v,
                                                  input logic [CHUNK_IDX_W-1:0] n);
    return v[CHUNK_W*n +: CHUNK_W];
  endfunction

  function automatic logic [INSN_W-1:0] li_word(input logic [DST_W-1:0]       dst,
                                                input logic [CHUNK_IDX_W-1:0] n,
                                                input logic [CHUNK_W-1:0]     imm);
    logic [INSN_W-1:0] w;
    w                  = '0;
    w[K_MSB:K_LSB]     = K_LOADIMM;
    w[DST_MSB:DST_LSB] = dst;
    w[K1_MSB:K1_LSB]   = k1_of(n);
    w[IMM_MSB:IMM_LSB] = imm;
    return w;
  endfunction

endpackage

// File: rtl/li_next_chunk.sv
// Next chunk index and last flag for a load-immediate sequence.
// LI_ENCODER_SKIP_ZERO_EN: skip zero upper chunks; otherwise all four chunks are emitted.
module li_next_chunk
  import li_encoder_pkg::*;
(
  input  logic [CHUNK_IDX_W-1:0] idx,
  input  logic [VALUE_W-1:0]     value,
  output logic [CHUNK_IDX_W-1:0] next_idx,
  output logic                   last
);

`ifdef LI_ENCODER_SKIP_ZERO_EN
  localparam bit SKIP_ZERO = 1'b1;
`else
  localparam bit SKIP_ZERO = 1'b0;
`endif

  always_comb begin
    next_idx = idx;
    last     = 1'b1;
    if (SKIP_ZERO) begin
      // Descending scan so the lowest non-zero chunk above idx wins.
      for (int n = NUM_CHUNKS - 1; n >= 1; n--) begin
        if (n > int'(idx) && li_chunk(value, CHUNK_IDX_W'(n)) != '0) begin
          next_idx = CHUNK_IDX_W'(n);
          last     = 1'b0;
        end
      end
    end else if (idx != CHUNK_IDX_W'(NUM_CHUNKS - 1)) begin
      next_idx = idx + 1'b1;
      last     = 1'b0;
    end
  end

endmodule

// File: rtl/li_encoder.sv
// Expands a 64-bit constant load into a sequence of LI/LIU/LIUU/LIUUU words.
// Optional LI_ENCODER_SKIP_ZERO_EN (in li_next_chunk) drops zero upper chunks.
module li_encoder
  import li_encoder_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic [DST_W-1:0]   i_dst,
  input  logic [VALUE_W-1:0] i_value,
  output logic               o_insn_valid,
  input  logic               i_insn_ready,
  output logic [INSN_W-1:0]  o_insn,
  output logic               o_last
);

  state_e                 state;
  state_e                 state_nxt;
  logic [DST_W-1:0]       dst_p0;
  logic [VALUE_W-1:0]     value_p0;
  logic [CHUNK_IDX_W-1:0] nxt_p0;
  logic                   accept;
  logic                   handshake;
  logic [CHUNK_IDX_W-1:0] probe_idx;
  logic [VALUE_W-1:0]     probe_value;
  logic [CHUNK_IDX_W-1:0] probe_next;
  logic                   probe_last;

  assign accept    = i_req_valid && o_req_ready;
  assign handshake = o_insn_valid && i_insn_ready;

  // In IDLE the probe looks at chunk 0 of the incoming value; in EMIT at the
  // chunk queued behind the word on o_insn, so o_last is ready when it loads.
  always_comb begin
    probe_idx   = nxt_p0;
    probe_value = value_p0;
    if (state == ST_IDLE) begin
      probe_idx   = '0;
      probe_value = i_value;
    end
  end

  li_next_chunk u_next_chunk (
    .idx      (probe_idx),
    .value    (probe_value),
    .next_idx (probe_next),
    .last     (probe_last)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    o_req_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        if (handshake && o_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // p0: latched operands and the registered output word
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dst_p0       <= '0;
      value_p0     <= '0;
      nxt_p0       <= '0;
      o_insn       <= '0;
      o_insn_valid <= 1'b0;
      o_last       <= 1'b0;
    end else if (accept) begin
      dst_p0       <= i_dst;
      value_p0     <= i_value;
      nxt_p0       <= probe_next;
      o_insn       <= li_word(i_dst, '0, li_chunk(i_value, '0));
      o_insn_valid <= 1'b1;
      o_last       <= probe_last;
    end else if (handshake) begin
      if (o_last) begin
        o_insn_valid <= 1'b0;
        o_last       <= 1'b0;
      end else begin
        o_insn <= li_word(dst_p0, nxt_p0, li_chunk(value_p0, nxt_p0));
        o_last <= probe_last;
        nxt_p0 <= probe_next;
      end
    end
  end

endmodule

// File: tb/tb_li_encoder.sv
// Self-checking bench for li_encoder: vector table, scoreboard queue and corner-case sequences.
// Expectations follow LI_ENCODER_SKIP_ZERO_EN when the macro is defined for the build.
module tb_li_encoder;

`ifdef LI_ENCODER_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        i_clk;
  logic        i_rst_n;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [4:0]  i_dst;
  logic [63:0] i_value;
  logic        o_insn_valid;
  logic        i_insn_ready;
  logic [31:0] o_insn;
  logic        o_last;

  li_encoder dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_dst        (i_dst),
    .i_value      (i_value),
    .o_insn_valid (o_insn_valid),
    .i_insn_ready (i_insn_ready),
    .o_insn       (o_insn),
    .o_last       (o_last)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] insn;
    logic        last;
  } exp_t;

  typedef struct {
    logic [4:0]  dst;
    logic [63:0] value;
    int          len_skip;
    int          len_full;
  } vec_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  int          words_seen = 0;
  logic        stalled = 1'b0;
  logic        expect_cont = 1'b0;
  logic [31:0] held_insn = '0;
  logic        held_last = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Independent model of the word sequence for one request.
  task automatic push_model(input logic [4:0] dst, input logic [63:0] value);
    logic [31:0] words[4];
    logic [15:0] imm;
    logic [1:0]  kk;
    int          cnt;
    cnt = 0;
    for (int n = 0; n < 4; n++) begin
      imm = 16'((value >> (16 * n)) & 64'hFFFF);
      kk  = 2'(n);
      if (n == 0 || !SKIP || imm != 16'h0) begin
        words[cnt] = {1'b0, 2'b01, 4'b0000, dst, 2'b00, kk, imm};
        cnt++;
      end
    end
    for (int i = 0; i < cnt; i++) q.push_back('{insn: words[i], last: (i == cnt - 1)});
  endtask

  task automatic monitor();
    exp_t e;
    if (!i_rst_n) begin
      stalled     = 1'b0;
      expect_cont = 1'b0;
    end else begin
      if (expect_cont) chk("no_bubble_valid", 64'(o_insn_valid), 64'd1);
      expect_cont = 1'b0;
      if (stalled) begin
        chk("stall_valid", 64'(o_insn_valid), 64'd1);
        chk("stall_insn", 64'(o_insn), 64'(held_insn));
        chk("stall_last", 64'(o_last), 64'(held_last));
      end
      if (o_insn_valid && i_insn_ready) begin
        words_seen++;
        stalled = 1'b0;
        expect_cont = !o_last;
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %h, expected no word", o_insn);
        end else begin
          e = q.pop_front();
          chk("insn", 64'(o_insn), 64'(e.insn));
          chk("last", 64'(o_last), 64'(e.last));
        end
      end else if (o_insn_valid) begin
        if (!stalled) begin
          held_insn = o_insn;
          held_last = o_last;
        end
        stalled = 1'b1;
      end else begin
        stalled = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
    monitor();
    @(posedge i_clk);
    #1;
  endtask

  // Returns #1 after the accepting edge, with the request dropped.
  task automatic send_raw(input logic [4:0] dst, input logic [63:0] value);
    int n;
    i_req_valid = 1'b1;
    i_dst       = dst;
    i_value     = value;
    n = 0;
    while (!o_req_ready && n < 200) begin
      tick();
      n++;
    end
    if (!o_req_ready) chk("req_ready_timeout", 64'(o_req_ready), 64'd1);
    tick();
    i_req_valid = 1'b0;
    chk("ready_low_after_accept", 64'(o_req_ready), 64'd0);
    chk("valid_after_accept", 64'(o_insn_valid), 64'd1);
  endtask

  task automatic drain(input bit rnd);
    int n;
    n = 0;
    while ((q.size() != 0 || !o_req_ready) && n < 400) begin
      if (rnd) i_insn_ready = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    i_insn_ready = 1'b1;
    if (q.size() != 0 || !o_req_ready) chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  vec_t vecs[6];
  int   w0;
  int   n_cyc;

  initial begin
    vecs[0] = '{dst: 5'd3,  value: 64'hDEAD_0000_BEEF_1234, len_skip: 3, len_full: 4};
    vecs[1] = '{dst: 5'd7,  value: 64'h0000_0000_0000_0000, len_skip: 1, len_full: 4};
    vecs[2] = '{dst: 5'd31, value: 64'hFFFF_FFFF_FFFF_FFFF, len_skip: 4, len_full: 4};
    vecs[3] = '{dst: 5'd0,  value: 64'h0000_0001_0000_0000, len_skip: 2, len_full: 4};
    vecs[4] = '{dst: 5'd12, value: 64'h8000_0000_0000_0001, len_skip: 2, len_full: 4};
    vecs[5] = '{dst: 5'd5,  value: 64'h0000_0000_ABCD_0000, len_skip: 2, len_full: 4};

    i_rst_n      = 1'b0;
    i_req_valid  = 1'b0;
    i_dst        = '0;
    i_value      = '0;
    i_insn_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_valid", 64'(o_insn_valid), 64'd0);
    chk("rst_last", 64'(o_last), 64'd0);
    chk("rst_insn", 64'(o_insn), 64'd0);
    chk("rst_ready", 64'(o_req_ready), 64'd1);
    i_rst_n = 1'b1;
    tick();

    // Reference sequence with literal words.
    if (SKIP) begin
      q.push_back('{insn: 32'h20301234, last: 1'b0});
      q.push_back('{insn: 32'h2031BEEF, last: 1'b0});
      q.push_back('{insn: 32'h2033DEAD, last: 1'b1});
    end else begin
      q.push_back('{insn: 32'h20301234, last: 1'b0});
      q.push_back('{insn: 32'h2031BEEF, last: 1'b0});
      q.push_back('{insn: 32'h20320000, last: 1'b0});
      q.push_back('{insn: 32'h2033DEAD, last: 1'b1});
    end
    w0 = words_seen;
    send_raw(5'd3, 64'hDEAD_0000_BEEF_1234);
    drain(1'b0);
    chk("ref_len", 64'(words_seen - w0), SKIP ? 64'd3 : 64'd4);

    // Zero value: ready returns after as many edges as words emitted.
    push_model(5'd7, 64'h0);
    send_raw(5'd7, 64'h0);
    n_cyc = 0;
    while (!o_req_ready && n_cyc < 20) begin
      tick();
      n_cyc++;
    end
    chk("zero_ready_cycles", 64'(n_cyc), SKIP ? 64'd1 : 64'd4);
    tick();

    for (int i = 0; i < 6; i++) begin
      w0 = words_seen;
      push_model(vecs[i].dst, vecs[i].value);
      send_raw(vecs[i].dst, vecs[i].value);
      drain(1'b1);
      chk($sformatf("vec%0d_len", i), 64'(words_seen - w0),
          64'(SKIP ? vecs[i].len_skip : vecs[i].len_full));
    end

    // Stall for 3 cycles while word 2 is presented.
    push_model(5'd9, 64'h1111_2222_3333_4444);
    send_raw(5'd9, 64'h1111_2222_3333_4444);
    tick();
    i_insn_ready = 1'b0;
    repeat (3) tick();
    chk("stall_word2", 64'(o_insn), 64'h20913333);
    i_insn_ready = 1'b1;
    drain(1'b0);

    // A second request held during EMIT waits for the first to finish.
    push_model(5'd4, 64'h0000_5555_0000_6666);
    send_raw(5'd4, 64'h0000_5555_0000_6666);
    i_req_valid = 1'b1;
    i_dst       = 5'd21;
    i_value     = 64'hAAAA_BBBB_CCCC_DDDD;
    chk("ready_in_emit", 64'(o_req_ready), 64'd0);
    tick();
    chk("ready_in_emit2", 64'(o_req_ready), 64'd0);
    push_model(5'd21, 64'hAAAA_BBBB_CCCC_DDDD);
    send_raw(5'd21, 64'hAAAA_BBBB_CCCC_DDDD);
    drain(1'b0);

    // Reset after the first word handshake aborts the sequence at once.
    push_model(5'd17, 64'hFFFF_FFFF_FFFF_FFFF);
    send_raw(5'd17, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("abort_valid", 64'(o_insn_valid), 64'd0);
    chk("abort_insn", 64'(o_insn), 64'd0);
    chk("abort_ready", 64'(o_req_ready), 64'd1);
    q.delete();
    tick();
    i_rst_n = 1'b1;
    repeat (6) tick();
    chk("post_abort_valid", 64'(o_insn_valid), 64'd0);
    chk("post_abort_ready", 64'(o_req_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
